// File: rtl/matrix_scan_arbiter.sv
// Frame buffer and row-scan driver for the 8x8 RGB LED matrix.
// Two writers share the buffer through a round-robin arbiter. Rows are scanned with a blanking gap between them.
module matrix_scan_arbiter #(
  parameter int DIV   = 5000,
  parameter int BLANK = 2
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [2:0] row_a,
  input  logic [2:0] row_b,
  input  logic [7:0] r_a,
  input  logic [7:0] g_a,
  input  logic [7:0] b_a,
  input  logic [7:0] r_b,
  input  logic [7:0] g_b,
  input  logic [7:0] b_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [7:0] DATA_R,
  output logic [7:0] DATA_G,
  output logic [7:0] DATA_B,
  output logic [2:0] COMM,
  output logic       EN,
  output logic       frame_tick
);
  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [7:0]  BLANK_LAST = 8'(BLANK - 1);

  typedef enum logic {S_SHOW, S_BLANK} state_t;

  state_t      state_q, state_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [7:0]  blank_cnt_q, blank_cnt_d;
  logic [2:0]  row_q, row_d;
  logic        last_b_q, last_b_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic [23:0] fb_q [0:7];
  logic [23:0] fb_d [0:7];
  logic [23:0] data_q, data_d;
  logic [2:0]  comm_q, comm_d;
  logic        en_q, en_d;
  logic        tick_q, tick_d;
  logic        row_start;

  // last_b_q set means B won most recently, so A takes the next tie.
  always_comb begin
    gnt_a_d  = req_a & (~req_b | last_b_q);
    gnt_b_d  = req_b & ~gnt_a_d;
    last_b_d = last_b_q;
    if (gnt_a_d) begin
      last_b_d = 1'b0;
    end else if (gnt_b_d) begin
      last_b_d = 1'b1;
    end
    fb_d = fb_q;
    if (gnt_a_d) begin
      fb_d[row_a] = {r_a, g_a, b_a};
    end else if (gnt_b_d) begin
      fb_d[row_b] = {r_b, g_b, b_b};
    end
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    blank_cnt_d = blank_cnt_q;
    row_d       = row_q;
    row_start   = 1'b0;
    case (state_q)
      S_SHOW: begin
        if (div_cnt_q == DIV_LAST) begin
          state_d   = S_BLANK;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      S_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          blank_cnt_d = '0;
          row_d       = row_q + 3'd1;
          state_d     = S_SHOW;
          row_start   = 1'b1;
        end else begin
          blank_cnt_d = blank_cnt_q + 8'd1;
        end
      end
    endcase

    // Outputs are registered for the state being entered; a new row reads
    // the buffer including any write landing on the same edge.
    en_d   = (state_d == S_SHOW);
    comm_d = row_d;
    tick_d = row_start & (row_d == 3'd0);
    if (row_start) begin
      data_d = fb_d[row_d];
    end else if (en_d) begin
      data_d = fb_q[row_q];
    end else begin
      data_d = 24'hFF_FFFF;
    end
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      state_q     <= S_SHOW;
      div_cnt_q   <= '0;
      blank_cnt_q <= '0;
      row_q       <= '0;
      last_b_q    <= 1'b1;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      data_q      <= 24'hFF_FFFF;
      comm_q      <= '0;
      en_q        <= 1'b0;
      tick_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        fb_q[i] <= 24'hFF_FFFF;
      end
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      row_q       <= row_d;
      last_b_q    <= last_b_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      data_q      <= data_d;
      comm_q      <= comm_d;
      en_q        <= en_d;
      tick_q      <= tick_d;
      fb_q        <= fb_d;
    end
  end

  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign DATA_R     = data_q[23:16];
  assign DATA_G     = data_q[15:8];
  assign DATA_B     = data_q[7:0];
  assign COMM       = comm_q;
  assign EN         = en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_matrix_scan_arbiter.sv
// Scoreboard bench for matrix_scan_arbiter with DIV=4, BLANK=2 (row period 6, frame period 48).
module tb_matrix_scan_arbiter;
  localparam int DIV_T   = 4;
  localparam int BLANK_T = 2;

  logic       CLK = 1'b0;
  logic       clear;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] row_a = '0, row_b = '0;
  logic [7:0] r_a = 8'hFF, g_a = 8'hFF, b_a = 8'hFF;
  logic [7:0] r_b = 8'hFF, g_b = 8'hFF, b_b = 8'hFF;
  logic       gnt_a, gnt_b;
  logic [7:0] DATA_R, DATA_G, DATA_B;
  logic [2:0] COMM;
  logic       EN, frame_tick;

  matrix_scan_arbiter #(.DIV(DIV_T), .BLANK(BLANK_T)) dut (
    .CLK(CLK), .clear(clear),
    .req_a(req_a), .req_b(req_b), .row_a(row_a), .row_b(row_b),
    .r_a(r_a), .g_a(g_a), .b_a(b_a), .r_b(r_b), .g_b(g_b), .b_b(b_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
    .COMM(COMM), .EN(EN), .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;

  int          vectors = 0;
  int          miscompares = 0;
  logic [1:0]  gq [$];
  logic [23:0] exp_fb [0:7];
  logic [23:0] b2b [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant monitor: every grant pulse must match the next queued expectation.
  initial forever begin
    @(negedge CLK);
    if (!clear && (gnt_a || gnt_b)) begin
      if (gq.size() == 0) check("unexpected_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
      else check("gnt_order", {30'd0, gnt_a, gnt_b}, {30'd0, gq.pop_front()});
    end
  end

  // Display monitor: row stepping, blanking, row content and frame ticks.
  logic       prev_en, seen_show, tick_valid;
  logic [2:0] last_row, exp_row;
  int         low_cnt, cyc, last_tick;
  initial begin
    prev_en = 0; seen_show = 0; tick_valid = 0; last_row = '0;
    low_cnt = 0; cyc = 0; last_tick = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (clear) begin
        prev_en = 0; seen_show = 0; tick_valid = 0; low_cnt = 0;
      end else begin
        if (EN && !prev_en) begin
          exp_row = seen_show ? last_row + 3'd1 : 3'd0;
          check("comm_step", {29'd0, COMM}, {29'd0, exp_row});
          check("row_data", {8'd0, DATA_R, DATA_G, DATA_B}, {8'd0, exp_fb[COMM]});
          check("frame_tick", {31'd0, frame_tick}, {31'd0, seen_show && COMM == 3'd0});
          if (seen_show) check("blank_len", low_cnt, BLANK_T);
          if (frame_tick) begin
            if (tick_valid) check("frame_period", cyc - last_tick, 8 * (DIV_T + BLANK_T));
            last_tick = cyc;
            tick_valid = 1;
          end
          seen_show = 1; last_row = COMM; low_cnt = 0;
        end else if (EN) begin
          check("comm_hold", {29'd0, COMM}, {29'd0, last_row});
          check("tick_mid", {31'd0, frame_tick}, 32'd0);
        end else begin
          low_cnt++;
          check("blank_data", {8'd0, DATA_R, DATA_G, DATA_B}, 32'h00FF_FFFF);
          if (seen_show) check("blank_comm", {29'd0, COMM}, {29'd0, last_row});
        end
        prev_en = EN;
      end
    end
  end

  // Returns at the negedge of the first lit cycle of row r.
  task automatic wait_first_show(input logic [2:0] r);
    int n = 0;
    logic [2:0] pr;
    pr = r - 3'd1;
    do begin @(negedge CLK); n++; end while (!(!EN && COMM == pr) && n < 200);
    do begin @(negedge CLK); n++; end while (!EN && n < 200);
    if (n >= 200) check("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic write_a(input logic [2:0] row, input logic [23:0] d);
    row_a = row; {r_a, g_a, b_a} = d; req_a = 1'b1;
    gq.push_back(2'b10);
    exp_fb[row] <= d;
    @(posedge CLK); @(negedge CLK);
    req_a = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_data", {8'd0, DATA_R, DATA_G, DATA_B}, 32'h00FF_FFFF);
    check("rst_comm", {29'd0, COMM}, 32'd0);
    check("rst_en", {31'd0, EN}, 32'd0);
    check("rst_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    b2b[0] = 24'hFE7F01; b2b[1] = 24'hFDBF02; b2b[2] = 24'hFBDF04; b2b[3] = 24'hF7EF08;
    b2b[4] = 24'hEFF710; b2b[5] = 24'hDFFB20; b2b[6] = 24'hBFFD40; b2b[7] = 24'h7FFE80;
    for (int i = 0; i < 8; i++) exp_fb[i] <= 24'hFF_FFFF;
    clear = 1'b0;
    #1 clear = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset_outputs();
    clear = 1'b0;
    @(negedge CLK);
    check("first_en", {31'd0, EN}, 32'd1);
    check("first_comm", {29'd0, COMM}, 32'd0);

    // Clear mid-scan with a pending request: no grant, outputs back to reset.
    wait_first_show(3'd2);
    row_a = 3'd1; {r_a, g_a, b_a} = 24'h000000; req_a = 1'b1;
    #2 clear = 1'b1;
    #1 check_reset_outputs();
    @(posedge CLK);
    #1 check("clear_no_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    req_a = 1'b0;
    @(negedge CLK);
    clear = 1'b0;
    repeat (60) @(negedge CLK);

    // Contention on row 5: A wins the first tie, then strict alternation.
    wait_first_show(3'd1);
    row_a = 3'd5; {r_a, g_a, b_a} = 24'h112233;
    row_b = 3'd5; {r_b, g_b, b_b} = 24'h445566;
    req_a = 1'b1; req_b = 1'b1;
    gq.push_back(2'b10); gq.push_back(2'b01); gq.push_back(2'b10); gq.push_back(2'b01);
    exp_fb[5] <= 24'h445566;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    req_a = 1'b0; req_b = 1'b0;
    wait_first_show(3'd5);
    check("contend_final", {8'd0, DATA_R, DATA_G, DATA_B}, 32'h00445566);

    // Single write from A to row 3.
    wait_first_show(3'd0);
    write_a(3'd3, 24'h3CFFFF);
    wait_first_show(3'd3);
    check("single_r", {24'd0, DATA_R}, 32'h3C);
    check("single_g", {24'd0, DATA_G}, 32'hFF);
    check("single_b", {24'd0, DATA_B}, 32'hFF);

    // Mid-row write from B to the lit row 6.
    wait_first_show(3'd6);
    row_b = 3'd6; {r_b, g_b, b_b} = 24'h5AA50F; req_b = 1'b1;
    gq.push_back(2'b01);
    @(posedge CLK); @(negedge CLK);
    req_b = 1'b0;
    check("midrow_old", {8'd0, DATA_R, DATA_G, DATA_B}, 32'h00FFFFFF);
    @(negedge CLK);
    check("midrow_new", {8'd0, DATA_R, DATA_G, DATA_B}, 32'h005AA50F);
    check("midrow_en", {31'd0, EN}, 32'd1);
    check("midrow_comm", {29'd0, COMM}, 32'd6);
    exp_fb[6] <= 24'h5AA50F;

    // Back-to-back writes from B to rows 0..7, one per cycle.
    wait_first_show(3'd0);
    req_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      row_b = 3'(i); {r_b, g_b, b_b} = b2b[i];
      gq.push_back(2'b01);
      exp_fb[i] <= b2b[i];
      @(posedge CLK); @(negedge CLK);
    end
    req_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_first_show(3'(i));
      check("b2b_row", {8'd0, DATA_R, DATA_G, DATA_B}, {8'd0, b2b[i]});
    end

    repeat (10) @(negedge CLK);
    check("gnt_pending", gq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/matrix_scan_arbiter.md
# matrix_scan_arbiter

Owns the 8x8 RGB LED matrix frame buffer and its row-scan drive. Two writers share the buffer through a round-robin request/grant port: requester A is game logic (falling objects and player), requester B is the overlay/message generator (GG screen, win screen). The scan sequencer time-multiplexes rows onto DATA_R/G/B and COMM, with a blanking gap between rows to suppress ghosting. It replaces ad-hoc per-always-block writes to the matrix outputs.

## Interface
- DIV, 5000: clock cycles each row is lit; legal range 1..65535.
- BLANK, 2: clock cycles the matrix is dark between rows; legal range 1..255.
- CLK  in  1  system clock.
- clear  in  1  asynchronous, active-high reset.
- req_a, req_b  in  1  write request from requester A / B; held high until granted.
- row_a, row_b  in  3  target row of the write.
- r_a, g_a, b_a, r_b, g_b, b_b  in  8 each  row data, active-low (0 = LED on).
- gnt_a, gnt_b  out  1  one-cycle grant; the write is committed on that clock edge.
- DATA_R, DATA_G, DATA_B  out  8 each  active-low column drive for the current row.
- COMM  out  3  current row index.
- EN  out  1  matrix enable; low during blanking.
- frame_tick  out  1  one-cycle pulse at the start of each frame (row 0 lit).

## Operation
- Frame buffer: 8 rows x 24 bits (R,G,B). Reset clears all entries to 8'hFF (all off).
- Arbiter, evaluated every cycle:
  - Only A requesting -> gnt_a; only B requesting -> gnt_b.
  - Both requesting -> grant the requester not granted most recently; the last-grant pointer resets to B, so A wins the first tie.
  - At most one grant per cycle. The granted row's R/G/B are written whole on the grant edge.
  - A requester still high after its grant is treated as a new request. Back-to-back writes from one requester are allowed when the other is idle.
- Scan FSM, two states:
  - SHOW: div_cnt counts 0..DIV-1. Each cycle EN=1, COMM=row, DATA_*=fb[row], all registered. At div_cnt==DIV-1 go to BLANK and clear the counter.
  - BLANK: blank_cnt counts 0..BLANK-1. EN=0, DATA_*=8'hFF, COMM holds the old row. At the last count: row <= row+1, wrapping 7->0; go to SHOW.
  - frame_tick=1 in the first SHOW cycle of row 0, except the first SHOW after reset.
- A write to the currently lit row takes effect mid-row. There is no tearing protection.
- Counters are 16-bit (div_cnt) and 8-bit (blank_cnt). row is 3-bit and wraps naturally.

## Timing
- Reset values: DATA_R/G/B=8'hFF, COMM=0, EN=0, gnt_a=gnt_b=0, frame_tick=0, state=SHOW, row=0, counters 0.
- First edge after clear falls: EN=1, COMM=0, DATA=fb[0].
- Write latency: the grant is a combinational response to req in the same cycle, registered out as gnt. The buffer updates on the grant edge. DATA reflects a write to the lit row one edge later.
- Row period = DIV+BLANK cycles. Frame period = 8*(DIV+BLANK) cycles.
- clear mid-frame: all state returns to reset immediately and asynchronously. Any pending write is dropped, with no grant.
- Simultaneous grant and row advance: the write lands. The new row reads the updated buffer if rows match.

## Test plan
- Reset: assert clear mid-scan -> every output at its reset value, and after release all 8 rows read 8'hFF.
- Single write: req_a, row_a=3, r_a=8'h3C, g_a=b_a=8'hFF -> gnt_a for 1 cycle; during row 3 SHOW, DATA_R=8'h3C and DATA_G=DATA_B=8'hFF.
- Contention: req_a and req_b both high for 4 cycles -> grants alternate A,B,A,B; final content equals the last-granted writer's data.
- Cadence with DIV=4, BLANK=2 -> COMM steps 0..7 every 6 cycles; EN low exactly 2 cycles per row with DATA=8'hFF; frame_tick every 48 cycles.
- Mid-row write: write row_b=COMM while EN=1 -> DATA changes one edge after gnt_b within the same SHOW interval.
- Back-to-back: req_b held 8 cycles, rows 0..7, req_a low -> 8 consecutive gnt_b pulses; next frame shows all 8 rows updated.
